// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - divider-stepped LED pattern engine (johnson/ring/bounce/binary); optional PWM dimming via LED_PWM_EN
module led_pattern_gen #(
    parameter int CLK_HZ  = 27_000_000,
    parameter int STEP_HZ = 2,
    parameter int WIDTH   = 8
) (
    input  logic             CLOCK_27,
    input  logic             RESET_N,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             run,
`ifdef LED_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic             step_tick,
    output logic             blink,
    output logic [WIDTH-1:0] leds
);

    localparam int LIMIT = CLK_HZ / STEP_HZ - 1;
    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_JOHNSON = 2'd0,
        MODE_RING    = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BINARY  = 2'd3
    } mode_t;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] pat_step;
    logic             bdir;
    logic             bdir_step;
    mode_t            mode_q;
    logic             mode_chg;

    function automatic logic [WIDTH-1:0] init_pat(input logic [1:0] m);
        return (m == MODE_RING || m == MODE_BOUNCE) ? ONE : '0;
    endfunction

    assign mode_chg = (mode != mode_q);

    // Next pattern if a step is taken this edge; bdir is only meaningful in bounce mode
    always_comb begin
        pat_step  = pattern;
        bdir_step = bdir;
        case (mode_q)
            MODE_JOHNSON: begin
                if (dir) pat_step = {~pattern[0], pattern[WIDTH-1:1]};
                else     pat_step = {pattern[WIDTH-2:0], ~pattern[WIDTH-1]};
            end
            MODE_RING: begin
                if (pattern == '0) pat_step = ONE;
                else if (dir)      pat_step = {pattern[0], pattern[WIDTH-1:1]};
                else               pat_step = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
            end
            MODE_BOUNCE: begin
                if (!bdir) begin
                    if (pattern[WIDTH-1]) begin
                        bdir_step = 1'b1;
                        pat_step  = pattern >> 1;
                    end else begin
                        pat_step  = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        bdir_step = 1'b0;
                        pat_step  = pattern << 1;
                    end else begin
                        pat_step  = pattern >> 1;
                    end
                end
            end
            MODE_BINARY: begin
                if (dir) pat_step = pattern - ONE;
                else     pat_step = pattern + ONE;
            end
            default: pat_step = pattern;
        endcase
    end

    always_ff @(posedge CLOCK_27) begin
        if (!RESET_N) begin
            cnt       <= '0;
            step_tick <= 1'b0;
            blink     <= 1'b0;
            mode_q    <= mode_t'(mode);
            pattern   <= init_pat(mode);
            bdir      <= dir;
        end else begin
            mode_q <= mode_t'(mode);
            if (step_tick) blink <= ~blink;
            // A mode change wins over a pending step and restarts the divider
            if (mode_chg) begin
                pattern   <= init_pat(mode);
                bdir      <= dir;
                cnt       <= '0;
                step_tick <= 1'b0;
            end else begin
                if (step_tick) begin
                    pattern <= pat_step;
                    bdir    <= bdir_step;
                end
                if (run) begin
                    if (cnt < LIMIT_C) begin
                        cnt       <= cnt + 1'b1;
                        step_tick <= 1'b0;
                    end else begin
                        cnt       <= '0;
                        step_tick <= 1'b1;
                    end
                end else begin
                    step_tick <= 1'b0;
                end
            end
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge CLOCK_27) begin
        if (!RESET_N) pwm_cnt <= '0;
        else          pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign leds = pattern & {WIDTH{pwm_cnt < duty}};
`else
    assign leds = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen against a step-index reference model
module tb_led_pattern_gen;

    logic       CLOCK_27 = 1'b0;
    logic       RESET_N;
    logic [1:0] mode;
    logic       dir;
    logic       run;
    logic       step_tick;
    logic       blink;
    logic [3:0] leds;
`ifdef LED_PWM_EN
    logic [3:0] duty = 4'd15;
`endif

    always #5 CLOCK_27 = ~CLOCK_27;

    led_pattern_gen #(.CLK_HZ(8), .STEP_HZ(2), .WIDTH(4)) dut (
        .CLOCK_27 (CLOCK_27),
        .RESET_N  (RESET_N),
        .mode     (mode),
        .dir      (dir),
        .run      (run),
`ifdef LED_PWM_EN
        .duty     (duty),
`endif
        .step_tick(step_tick),
        .blink    (blink),
        .leds     (leds)
    );

    int checks   = 0;
    int failures = 0;

    // Model: each mode's pattern is a position along its sequence
    int m_cnt, m_pos, m_pwm, m_mode;
    bit m_tick, m_blink, m_bdir;

    function automatic logic [3:0] exp_pattern();
        int k;
        k = m_pos;
        case (m_mode)
            0:       return (k <= 4) ? 4'((1 << k) - 1) : 4'(15 & ~((1 << (k - 4)) - 1));
            1, 2:    return 4'(1 << k);
            default: return 4'(k);
        endcase
    endfunction

    function automatic logic [3:0] exp_leds();
`ifdef LED_PWM_EN
        return (m_pwm < int'(duty)) ? exp_pattern() : 4'b0000;
`else
        return exp_pattern();
`endif
    endfunction

    task automatic advance();
        case (m_mode)
            0: m_pos = dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
            1: m_pos = dir ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
            2: begin
                if (!m_bdir) begin
                    if (m_pos == 3) begin m_bdir = 1; m_pos = 2; end
                    else m_pos = m_pos + 1;
                end else begin
                    if (m_pos == 0) begin m_bdir = 0; m_pos = 1; end
                    else m_pos = m_pos - 1;
                end
            end
            default: m_pos = dir ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
        endcase
    endtask

    task automatic model_edge();
        bit t;
        if (!RESET_N) begin
            m_cnt = 0; m_tick = 0; m_blink = 0; m_pwm = 0;
            m_mode = int'(mode); m_pos = 0; m_bdir = dir;
        end else begin
            t = m_tick;
            m_pwm = (m_pwm + 1) % 16;
            if (t) m_blink = !m_blink;
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode); m_pos = 0; m_bdir = dir; m_cnt = 0; m_tick = 0;
            end else begin
                if (t) advance();
                if (run) begin
                    if (m_cnt == 3) begin m_cnt = 0; m_tick = 1; end
                    else begin m_cnt = m_cnt + 1; m_tick = 0; end
                end else begin
                    m_tick = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_27);
        model_edge();
        #1;
        checks++;
        assert (step_tick === m_tick) else begin
            failures++;
            $error("FAIL step_tick got=%0b exp=%0b t=%0t", step_tick, m_tick, $time);
        end
        checks++;
        assert (blink === m_blink) else begin
            failures++;
            $error("FAIL blink got=%0b exp=%0b t=%0t", blink, m_blink, $time);
        end
        checks++;
        assert (leds === exp_leds()) else begin
            failures++;
            $error("FAIL leds got=%b exp=%b mode=%0d t=%0t", leds, exp_leds(), m_mode, $time);
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        cycle();
        RESET_N = 1'b1;
    endtask

    initial begin
        int n;
        RESET_N = 1'b0; mode = 2'd0; dir = 1'b0; run = 1'b1;

        // Johnson left from reset
        do_reset();
        repeat (36) cycle();

        // Bounce via mode entry
        mode = 2'd2;
        repeat (30) cycle();

        // Binary down from reset, freeze, resume
        mode = 2'd3; dir = 1'b1;
        do_reset();
        repeat (12) cycle();
        run = 1'b0;
        repeat (20) cycle();
        run = 1'b1;
        repeat (10) cycle();

        // Mode switch coincident with a tick while johnson shows 0111
        mode = 2'd0; dir = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (!(m_mode == 0 && m_pos == 3 && m_tick) && n < 200);
        checks++;
        assert (n < 200) else begin
            failures++;
            $error("FAIL johnson_0111_wait got=%0d exp=<200", n);
        end
        mode = 2'd1;
        repeat (12) cycle();

        // Reset while ring shows 0100; glitches between edges are ignored
        n = 0;
        do begin cycle(); n++; end while (!(m_pos == 2) && n < 200);
        checks++;
        assert (n < 200) else begin
            failures++;
            $error("FAIL ring_0100_wait got=%0d exp=<200", n);
        end
        do_reset();
        repeat (10) begin
            #1 RESET_N = 1'b0;
            #2 RESET_N = 1'b1;
            cycle();
        end

`ifdef LED_PWM_EN
        duty = 4'd0;
        repeat (20) cycle();
        duty = 4'd4;
        repeat (20) cycle();
        duty = 4'd15;
`endif

        // Randomised run/dir/mode/reset traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  dir  = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 7) != 0);
`ifdef LED_PWM_EN
            if ($urandom_range(0, 29) == 0) duty = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 59) == 0) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
